// File: rtl/hazard_game_ctrl.sv
// hazard_game_ctrl: LFSR hazard grid game controller with lives,
// post-hit cooldown and saturating survival score.
// Ports: clk, rst (async high), tick (game-rate strobe),
//   start_op (level button), box (player cells) ->
//   game_state (00 INIT/01 PLAY/10 FINISH), fire_state,
//   life, score, hit_flag (damage pulse), high_score.
// Optional: define HAZARD_HIGH_SCORE_EN to keep the best
//   score since reset; otherwise high_score is tied to 0.
module hazard_game_ctrl #(
  parameter int                 N_CELLS      = 9,
  parameter logic [N_CELLS-1:0] TAP_MASK     = 9'h131,
  parameter logic [N_CELLS-1:0] SEED         = 9'h124,
  parameter int                 LIFE_INIT    = 3,
  parameter int                 LIFE_W       = 2,
  parameter int                 SCORE_W      = 8,
  parameter int                 HIT_COOLDOWN = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start_op,
  input  logic [N_CELLS-1:0] box,
  output logic [1:0]         game_state,
  output logic [N_CELLS-1:0] fire_state,
  output logic [LIFE_W-1:0]  life,
  output logic [SCORE_W-1:0] score,
  output logic               hit_flag,
  output logic [SCORE_W-1:0] high_score
);

  localparam int HW  = $clog2(N_CELLS + 1);
  localparam int CW  = (HW > LIFE_W) ? HW : LIFE_W;
  localparam int CDW = (HIT_COOLDOWN > 0) ?
                       $clog2(HIT_COOLDOWN + 1) : 1;

  typedef enum logic [1:0] {
    S_INIT   = 2'b00,
    S_PLAY   = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic               start_q, start_re;
  logic [N_CELLS-1:0] fire_q, fire_shift, fire_next;
  logic [LIFE_W-1:0]  life_q, life_dmg;
  logic [SCORE_W-1:0] score_q;
  logic [CDW-1:0]     cd_q;
  logic               hit_q;
  logic [HW-1:0]      hits;
  logic [CW-1:0]      hits_x, life_x;
  logic               fb;
  logic               do_init, do_tick, damage, end_game;

  assign start_re = start_op & ~start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_q <= 1'b0;
    else     start_q <= start_op;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   if (start_re)      state_d = S_PLAY;
      S_PLAY:   if (life_q == '0)  state_d = S_FINISH;
      S_FINISH: if (start_re)      state_d = S_INIT;
      default:                     state_d = S_INIT;
    endcase
  end

  // FSM outputs / datapath controls
  always_comb begin
    game_state = state_q;
    do_init    = (state_q == S_INIT);
    do_tick    = (state_q == S_PLAY) && tick;
    end_game   = (state_q == S_PLAY) &&
                 (state_d == S_FINISH);
  end

  always_comb begin
    hits = '0;
    for (int i = 0; i < N_CELLS; i++)
      hits = hits + HW'(box[i] & fire_q[i]);
  end

  assign fb         = ^(fire_q & TAP_MASK);
  assign fire_shift = {fire_q[N_CELLS-2:0], fb};
  // an all-zero LFSR would never leave zero, so reseed
  assign fire_next  = (fire_shift == '0) ?
                      SEED : fire_shift;

  assign hits_x   = CW'(hits);
  assign life_x   = CW'(life_q);
  assign life_dmg = (hits_x >= life_x) ? '0 :
                    life_q - LIFE_W'(hits);
  assign damage   = do_tick && (cd_q == '0) &&
                    (hits != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_q  <= SEED;
      life_q  <= LIFE_W'(LIFE_INIT);
      score_q <= '0;
      cd_q    <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= damage;
      if (do_init) begin
        fire_q  <= SEED;
        life_q  <= LIFE_W'(LIFE_INIT);
        score_q <= '0;
        cd_q    <= '0;
      end else if (do_tick) begin
        fire_q <= fire_next;
        if (damage) begin
          life_q <= life_dmg;
          cd_q   <= CDW'(HIT_COOLDOWN);
        end else if (cd_q != '0) begin
          cd_q <= cd_q - 1'b1;
        end
        if (hits == '0 && score_q != '1)
          score_q <= score_q + 1'b1;
      end
    end
  end

  assign fire_state = fire_q;
  assign life       = life_q;
  assign score      = score_q;
  assign hit_flag   = hit_q;

`ifdef HAZARD_HIGH_SCORE_EN
  logic [SCORE_W-1:0] hs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hs_q <= '0;
    else if (end_game && score_q > hs_q)
      hs_q <= score_q;
  end

  assign high_score = hs_q;
`else
  logic unused_end_game;
  assign unused_end_game = end_game;
  assign high_score      = '0;
`endif

endmodule
